fetch_decode_queue: RTL and testbench

- Parametrised successor to the single-entry fetch/decode pipeline register.
- Sits between instruction fetch and decode as a DEPTH-entry FIFO of {tag, pc, instr} bundles with valid/ready handshakes on both sides.
- Provides synchronous flush with a bubble (NOP) bundle carrying a redirect PC, and per-push PC override for jump redirection.
- Lets fetch run ahead of a stalled decode stage without losing or duplicating instructions.

---
 rtl/fetch_decode_queue.sv | 110 +++++++++++
 tb/tb_fetch_decode_queue.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_decode_queue.sv
// Fetch-to-decode FIFO of {tag, pc, instr} bundles with valid/ready on both sides.
// Flush empties the queue and parks a NOP bubble carrying the redirect PC at the output.
module fetch_decode_queue #(
  parameter int unsigned          INSTR_W   = 32,
  parameter int unsigned          ADDR_W    = 32,
  parameter int unsigned          DEPTH     = 4,
  parameter logic [INSTR_W-1:0]   NOP_INSTR = 32'h00000008
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [INSTR_W-1:0]            in_instr,
  input  logic [ADDR_W-1:0]             in_pc,
  input  logic                          in_tag,
  input  logic                          jump_valid,
  input  logic [ADDR_W-1:0]             jump_pc,
  input  logic                          flush,
  input  logic [ADDR_W-1:0]             flush_pc,
  input  logic                          flush_tag,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [ADDR_W+INSTR_W:0]       out_bundle,
  output logic [$clog2(DEPTH+1)-1:0]    count
);

  localparam int unsigned PtrW    = $clog2(DEPTH);
  localparam int unsigned CntW    = $clog2(DEPTH+1);
  localparam int unsigned BundleW = 1 + ADDR_W + INSTR_W;
  localparam logic [CntW-1:0] DepthCnt = CntW'(DEPTH);

  logic [BundleW-1:0] mem_q [DEPTH];

  logic [PtrW-1:0]   head_q, head_d;
  logic [PtrW-1:0]   tail_q, tail_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              bubble_tag_q, bubble_tag_d;
  logic [ADDR_W-1:0] bubble_pc_q, bubble_pc_d;

  logic              push;
  logic              pop;
  logic              mem_we;
  logic [BundleW-1:0] wr_bundle;

  // Full queue never accepts, even with a concurrent pop: no pass-through path.
  assign in_ready  = (count_q != DepthCnt);
  assign out_valid = (count_q != '0);
  assign count     = count_q;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign mem_we = push && !flush;

  assign wr_bundle = {in_tag, (jump_valid ? jump_pc : in_pc), in_instr};

  // Output comes only from registered state, so in_* never reaches out_* combinationally.
  assign out_bundle = out_valid ? mem_q[head_q] : {bubble_tag_q, bubble_pc_q, NOP_INSTR};

  always_comb begin
    head_d       = head_q;
    tail_d       = tail_q;
    count_d      = count_q;
    bubble_tag_d = bubble_tag_q;
    bubble_pc_d  = bubble_pc_q;

    if (flush) begin
      head_d       = '0;
      tail_d       = '0;
      count_d      = '0;
      bubble_tag_d = flush_tag;
      bubble_pc_d  = flush_pc;
    end else begin
      if (push) begin
        tail_d = tail_q + PtrW'(1);
      end
      if (pop) begin
        head_d = head_q + PtrW'(1);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      bubble_tag_q <= 1'b0;
      bubble_pc_q  <= '0;
    end else begin
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      bubble_tag_q <= bubble_tag_d;
      bubble_pc_q  <= bubble_pc_d;
    end
  end

  // Storage is never read while its slot is unoccupied, so it needs no reset.
  always_ff @(negedge clk) begin
    if (mem_we) begin
      mem_q[tail_q] <= wr_bundle;
    end
  end

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Randomised bench for fetch_decode_queue against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DEPTH   = 4;
  localparam logic [31:0] NOP     = 32'h00000008;
  localparam int unsigned BW      = 1 + ADDR_W + INSTR_W;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [ADDR_W-1:0] in_pc;
  logic              in_tag;
  logic              jump_valid;
  logic [ADDR_W-1:0] jump_pc;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  logic              flush_tag;
  logic              out_valid;
  logic              out_ready;
  logic [BW-1:0]     out_bundle;
  logic [2:0]        count;

  fetch_decode_queue #(
    .INSTR_W  (INSTR_W),
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .NOP_INSTR(NOP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_pc     (in_pc),
    .in_tag    (in_tag),
    .jump_valid(jump_valid),
    .jump_pc   (jump_pc),
    .flush     (flush),
    .flush_pc  (flush_pc),
    .flush_tag (flush_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_bundle(out_bundle),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain FIFO of bundles plus the bubble fields.
  logic [BW-1:0]     model_q[$];
  logic              bub_tag;
  logic [ADDR_W-1:0] bub_pc;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int sz;
    logic [BW-1:0] exp_b;
    sz = model_q.size();
    exp_b = (sz != 0) ? model_q[0] : {bub_tag, bub_pc, NOP};
    check_eq("count", 128'(count), 128'(sz));
    check_eq("in_ready", 128'(in_ready), 128'(sz < DEPTH));
    check_eq("out_valid", 128'(out_valid), 128'(sz != 0));
    check_eq("out_bundle", 128'(out_bundle), 128'(exp_b));
  endtask

  task automatic model_reset();
    model_q.delete();
    bub_tag = 1'b0;
    bub_pc  = '0;
  endtask

  task automatic idle_inputs();
    in_valid   = 1'b0;
    in_instr   = '0;
    in_pc      = '0;
    in_tag     = 1'b0;
    jump_valid = 1'b0;
    jump_pc    = '0;
    flush      = 1'b0;
    flush_pc   = '0;
    flush_tag  = 1'b0;
    out_ready  = 1'b0;
  endtask

  // Inputs are already set; advance one active (negative) edge, update model, compare.
  task automatic tick();
    int sz;
    bit push_ok;
    bit pop_ok;
    logic [BW-1:0] nb;
    sz      = model_q.size();
    push_ok = in_valid && (sz < DEPTH);
    pop_ok  = out_ready && (sz > 0);
    nb      = {in_tag, (jump_valid ? jump_pc : in_pc), in_instr};
    @(negedge clk);
    if (flush) begin
      model_q.delete();
      bub_tag = flush_tag;
      bub_pc  = flush_pc;
    end else begin
      if (pop_ok) void'(model_q.pop_front());
      if (push_ok) model_q.push_back(nb);
    end
    #1;
    check_outputs();
  endtask

  task automatic push_one(input logic [31:0] pc, input logic [31:0] instr, input logic rdy);
    idle_inputs();
    in_valid  = 1'b1;
    in_pc     = pc;
    in_instr  = instr;
    in_tag    = pc[2];
    out_ready = rdy;
    tick();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    model_reset();
    #3;
    check_outputs();
    check_eq("reset_bundle", 128'(out_bundle), 128'({1'b0, 32'h0, NOP}));
    reset = 1'b1;

    // Fill to full, fifth push ignored, then drain in order.
    push_one(32'h10, 32'hA, 1'b0);
    push_one(32'h14, 32'hB, 1'b0);
    push_one(32'h18, 32'hC, 1'b0);
    push_one(32'h1C, 32'hD, 1'b0);
    check_eq("full_in_ready", 128'(in_ready), 128'(0));
    push_one(32'h20, 32'hE, 1'b1);
    check_eq("full_pop_count", 128'(count), 128'(3));
    for (int i = 0; i < 4; i++) begin
      idle_inputs();
      out_ready = 1'b1;
      tick();
    end
    check_eq("drained_valid", 128'(out_valid), 128'(0));

    // Steady-state streaming at occupancy 2 across pointer wrap.
    push_one(32'h30, 32'h100, 1'b0);
    push_one(32'h34, 32'h101, 1'b0);
    for (int i = 0; i < 10; i++) begin
      push_one(32'h38 + 32'(4 * i), 32'h102 + 32'(i), 1'b1);
      check_eq("stream_count", 128'(count), 128'(2));
    end
    for (int i = 0; i < 2; i++) begin
      idle_inputs();
      out_ready = 1'b1;
      tick();
    end

    // Jump override on push into an empty queue: visible after one edge.
    idle_inputs();
    in_valid   = 1'b1;
    in_pc      = 32'h40;
    in_instr   = 32'hDEAD_BEEF;
    in_tag     = 1'b1;
    jump_valid = 1'b1;
    jump_pc    = 32'h100;
    tick();
    check_eq("jump_bundle", 128'(out_bundle), 128'({1'b1, 32'h100, 32'hDEAD_BEEF}));

    // Flush with 3 entries plus a concurrent push and pop.
    push_one(32'h44, 32'h11, 1'b0);
    push_one(32'h48, 32'h12, 1'b0);
    idle_inputs();
    in_valid  = 1'b1;
    in_pc     = 32'h4C;
    in_instr  = 32'h13;
    out_ready = 1'b1;
    flush     = 1'b1;
    flush_pc  = 32'h200;
    flush_tag = 1'b1;
    tick();
    check_eq("flush_bundle", 128'(out_bundle), 128'({1'b1, 32'h200, NOP}));
    check_eq("flush_count", 128'(count), 128'(0));
    idle_inputs();
    tick();

    // Async reset between edges with 2 entries queued.
    push_one(32'h60, 32'h21, 1'b0);
    push_one(32'h64, 32'h22, 1'b0);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_eq("async_rst_count", 128'(count), 128'(0));
    check_eq("async_rst_bundle", 128'(out_bundle), 128'({1'b0, 32'h0, NOP}));
    #1;
    reset = 1'b1;
    idle_inputs();
    tick();

    // Randomised traffic with occasional flushes, jumps and reset pulses.
    for (int i = 0; i < 1500; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      in_instr   = $urandom;
      in_pc      = $urandom;
      in_tag     = 1'($urandom);
      jump_valid = ($urandom_range(0, 5) == 0);
      jump_pc    = $urandom;
      flush      = ($urandom_range(0, 30) == 0);
      flush_pc   = $urandom;
      flush_tag  = 1'($urandom);
      out_ready  = ($urandom_range(0, 2) != 0);
      tick();
      if ($urandom_range(0, 150) == 0) begin
        #1;
        reset = 1'b0;
        model_reset();
        #1;
        check_outputs();
        reset = 1'b1;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
